// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: header field layout, illegal address
// code and the packet transmitter state encoding.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_t;

  // Header byte carries the payload length above the destination address.
  function automatic logic [LEN_W+ADDR_W-1:0] make_header(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/tx_payload_buf.sv
// Payload staging memory: synchronous write port, combinational read port.
module tx_payload_buf #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; every entry is written before it is read.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers a payload, then streams
// header, payload and parity bytes, stalling on busy, and counts err edges.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int BUF_DEPTH  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic              inject_err,
  input  logic [7:0]        pld_data,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic              busy,
  input  logic              err,
  output logic [7:0]        data_out,
  output logic              pkt_valid,
  output logic              tx_active,
  output logic              done,
  output logic              start_err,
  output logic [7:0]        err_cnt
);

  tx_state_t        state;
  logic [7:0]       hdr_q;
  logic [7:0]       parity_q;
  logic             inj_q;
  logic [LEN_W-1:0] wptr;
  logic [LEN_W-1:0] rptr;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       gap_cnt;
  logic             err_d;
  logic [7:0]       rd_data;
  logic             wr_en;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign len_q = hdr_q[ADDR_W +: LEN_W];
  assign wr_en = (state == LOAD) && pld_valid && pld_ready;

  tx_payload_buf #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (LEN_W),
    .DATA_W (8)
  ) u_buf (
    .clock (clock),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (pld_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hdr_q     <= '0;
      parity_q  <= '0;
      inj_q     <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      gap_cnt   <= '0;
      err_d     <= 1'b0;
      err_cnt   <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      pld_ready <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      start_err <= 1'b0;
      err_d     <= err;
      if (err && !err_d) err_cnt <= sat_inc(err_cnt);

      case (state)
        IDLE: begin
          if (start) begin
            if (dest_addr != ADDR_INVALID && payload_len != '0) begin
              hdr_q     <= make_header(payload_len, dest_addr);
              parity_q  <= make_header(payload_len, dest_addr);
              inj_q     <= inject_err;
              wptr      <= '0;
              rptr      <= '0;
              pld_ready <= 1'b1;
              tx_active <= 1'b1;
              state     <= LOAD;
            end else begin
              start_err <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (wr_en) begin
            parity_q <= parity_q ^ pld_data;
            wptr     <= wptr + LEN_W'(1);
            if (wptr == len_q - LEN_W'(1)) begin
              pld_ready <= 1'b0;
              data_out  <= hdr_q;
              pkt_valid <= 1'b1;
              state     <= HEADER;
            end
          end
        end

        HEADER: begin
          if (!busy) begin
            data_out <= rd_data;
            rptr     <= rptr + LEN_W'(1);
            state    <= PAYLOAD;
          end
        end

        // rptr always points one past the byte currently on data_out.
        PAYLOAD: begin
          if (!busy) begin
            if (rptr != len_q) begin
              data_out <= rd_data;
              rptr     <= rptr + LEN_W'(1);
            end else begin
              data_out  <= parity_q ^ {7'b0, inj_q};
              pkt_valid <= 1'b0;
              state     <= PARITY;
            end
          end
        end

        PARITY: begin
          if (!busy) begin
            done     <= 1'b1;
            data_out <= '0;
            gap_cnt  <= '0;
            state    <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            tx_active <= 1'b0;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected byte stream is queued per
// packet from header/payload/parity rules; a negedge monitor compares.
module tb_router_pkt_tx;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       inject_err;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_ready;
  logic       busy;
  logic       err;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       done;
  logic       start_err;
  logic [7:0] err_cnt;

  logic busy_force, busy_rnd, busy_en, err_en;

  typedef struct {
    logic [7:0] d;
    logic       pv;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] pld_buf [64];
  int         total, bad;
  int         done_cnt, exp_done;
  int         err_model;

  router_pkt_tx #(.GAP_CYCLES(2), .BUF_DEPTH(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .inject_err  (inject_err),
    .pld_data    (pld_data),
    .pld_valid   (pld_valid),
    .pld_ready   (pld_ready),
    .busy        (busy),
    .err         (err),
    .data_out    (data_out),
    .pkt_valid   (pkt_valid),
    .tx_active   (tx_active),
    .done        (done),
    .start_err   (start_err),
    .err_cnt     (err_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign busy = busy_force | busy_rnd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic int sat255(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Monitor: a byte is consumed at the edge following a negedge with busy=0.
  initial begin
    logic [7:0] prev_d;
    logic       prev_pv, prev_busy, prev_done;
    exp_t       e;
    prev_d = '0; prev_pv = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (done) begin
          done_cnt++;
          if (prev_done) timeout_fail("done_width");
          if (sb_q.size() == 0) timeout_fail("parity_unexpected");
          else begin
            e = sb_q.pop_front();
            chk("parity_data", prev_d, e.d);
            chk("parity_pv", prev_pv, e.pv);
            chk("parity_busy", prev_busy, 0);
          end
        end
        if (pkt_valid && !busy) begin
          if (sb_q.size() == 0) timeout_fail("byte_unexpected");
          else begin
            e = sb_q.pop_front();
            chk("byte_data", data_out, e.d);
            chk("byte_pv", pkt_valid, e.pv);
          end
        end
      end
      prev_d = data_out; prev_pv = pkt_valid; prev_busy = busy; prev_done = done;
    end
  end

  initial begin
    busy_rnd = 1'b0;
    forever begin
      @(posedge clock); #1;
      busy_rnd = busy_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  initial begin
    logic nv;
    forever begin
      @(posedge clock); #1;
      if (err_en) begin
        nv = ($urandom_range(0, 7) == 0);
        if (nv && !err) err_model = sat255(err_model);
        err = nv;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clock); n++; end while (tx_active && n < 500);
    if (tx_active) timeout_fail("wait_idle");
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < exp_done && n < 2000) begin @(negedge clock); n++; end
    if (done_cnt < exp_done) timeout_fail("wait_done");
  endtask

  task automatic load_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj, input logic gaps);
    logic [7:0] hdr, par;
    int n;
    wait_idle();
    hdr = {l, a};
    par = hdr;
    sb_q.push_back('{hdr, 1'b1});
    for (int i = 0; i < int'(l); i++) begin
      sb_q.push_back('{pld_buf[i], 1'b1});
      par = par ^ pld_buf[i];
    end
    par[0] = par[0] ^ inj;
    sb_q.push_back('{par, 1'b0});
    exp_done++;
    @(posedge clock); #1;
    start = 1'b1; dest_addr = a; payload_len = l; inject_err = inj;
    @(posedge clock); #1;
    start = 1'b0; dest_addr = 2'($urandom); payload_len = 6'($urandom); inject_err = 1'($urandom);
    for (int i = 0; i < int'(l); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
      pld_valid = 1'b1; pld_data = pld_buf[i];
      n = 0;
      do begin @(negedge clock); n++; end while (!pld_ready && n < 100);
      if (!pld_ready) timeout_fail("pld_ready");
      @(posedge clock); #1;
      pld_valid = 1'b0; pld_data = 8'($urandom);
    end
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_data_out"}, data_out, 0);
    chk({nm, "_pkt_valid"}, pkt_valid, 0);
    chk({nm, "_pld_ready"}, pld_ready, 0);
    chk({nm, "_tx_active"}, tx_active, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_start_err"}, start_err, 0);
    chk({nm, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    int n;
    logic [5:0] rl;
    total = 0; bad = 0; done_cnt = 0; exp_done = 0; err_model = 0;
    reset = 1'b1; start = 1'b0; dest_addr = '0; payload_len = '0; inject_err = 1'b0;
    pld_data = '0; pld_valid = 1'b0; err = 1'b0;
    busy_force = 1'b0; busy_en = 1'b0; err_en = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_quiet("reset");
    #1 reset = 1'b0;

    // Basic packet, gap-free timing.
    pld_buf[0] = 8'h11; pld_buf[1] = 8'h22; pld_buf[2] = 8'h33;
    load_pkt(2'd1, 6'd3, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge clock); n++; end while (!done && n < 200);
    chk("latency_to_done", n, 3 + 3);
    wait_done();

    // Busy stall on the second payload byte.
    load_pkt(2'd1, 6'd3, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge clock); n++; end while (!(pkt_valid && data_out == 8'h11) && n < 200);
    @(posedge clock); #1 busy_force = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("hold_data", data_out, 8'h22);
      chk("hold_pv", pkt_valid, 1);
      @(posedge clock);
    end
    #1 busy_force = 1'b0;
    wait_done();

    // Illegal starts.
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      start = 1'b1; dest_addr = (k == 0) ? 2'd3 : 2'd1; payload_len = (k == 0) ? 6'd5 : 6'd0;
      @(posedge clock); #1 start = 1'b0;
      @(negedge clock);
      chk("illegal_start_err", start_err, 1);
      chk("illegal_pld_ready", pld_ready, 0);
      chk("illegal_tx_active", tx_active, 0);
      @(negedge clock);
      chk("illegal_start_err_pulse", start_err, 0);
      chk("illegal_tx_active2", tx_active, 0);
    end

    // Injected parity error, then router err pulse and a clean packet.
    load_pkt(2'd1, 6'd3, 1'b1, 1'b0);
    wait_done();
    @(posedge clock); #1 err = 1'b1; err_model = sat255(err_model);
    @(posedge clock); #1 err = 1'b0;
    repeat (2) @(negedge clock);
    chk("err_cnt_one", err_cnt, err_model);
    load_pkt(2'd1, 6'd3, 1'b0, 1'b0);
    wait_done();
    chk("err_cnt_unchanged", err_cnt, err_model);

    // Maximum length packet.
    for (int i = 0; i < 63; i++) pld_buf[i] = 8'(i);
    load_pkt(2'd2, 6'd63, 1'b0, 1'b1);
    wait_done();

    // Randomized traffic with busy stalls and err pulses.
    busy_en = 1'b1; err_en = 1'b1;
    for (int p = 0; p < 15; p++) begin
      rl = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'($urandom_range(1, 8));
      for (int i = 0; i < 64; i++) pld_buf[i] = 8'($urandom);
      load_pkt(2'($urandom_range(0, 2)), rl, 1'($urandom), 1'b1);
      wait_done();
    end
    busy_en = 1'b0; err_en = 1'b0;
    @(posedge clock); #2 err = 1'b0;
    repeat (3) @(negedge clock);
    chk("err_cnt_random", err_cnt, err_model);

    // Saturation of the err counter.
    repeat (260) begin
      @(posedge clock); #1 err = 1'b1; err_model = sat255(err_model);
      @(posedge clock); #1 err = 1'b0;
    end
    repeat (2) @(negedge clock);
    chk("err_cnt_saturate", err_cnt, 255);

    // Reset while the second payload byte is on the bus.
    pld_buf[0] = 8'hA1; pld_buf[1] = 8'hB2; pld_buf[2] = 8'hC3; pld_buf[3] = 8'hD4; pld_buf[4] = 8'hE5;
    load_pkt(2'd0, 6'd5, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge clock); n++; end while (!(pkt_valid && data_out == 8'hB2) && n < 200);
    if (n >= 200) timeout_fail("wait_second_byte");
    #2 reset = 1'b1;
    #1;
    check_quiet("midreset");
    sb_q.delete();
    exp_done--;
    err_model = 0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    for (int i = 0; i < 64; i++) pld_buf[i] = 8'($urandom);
    load_pkt(2'd2, 6'd7, 1'b0, 1'b0);
    wait_done();

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("done_count", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source for the 1x3 router's input port. It generates the byte stream that the router's input register and FSM consume.
- Accepts a destination address, a payload length and the payload bytes from a test or host side, and buffers the whole payload.
- Then drives header, payload and parity bytes on data_out/pkt_valid without gaps, honouring router busy.
- Also counts err pulses returned by the router.

Parameters:
- GAP_CYCLES, 2: idle cycles with pkt_valid=0 inserted after each parity byte before a new start is accepted.
- BUF_DEPTH, 64: payload buffer entries; fixed by the 6-bit length field (max 63 bytes used).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to send one packet; sampled in IDLE only.
- dest_addr  in  2  destination port 0..2; value 3 is illegal.
- payload_len  in  6  payload bytes, 1..63; 0 is illegal.
- inject_err  in  1  sampled with start; when 1, the parity byte is sent with bit 0 inverted.
- pld_data  in  8  payload byte from host.
- pld_valid  in  1  pld_data valid.
- pld_ready  out  1  block accepts a payload byte this cycle.
- busy  in  1  router busy; current byte is held while high.
- err  in  1  router parity error flag.
- data_out  out  8  byte to router data_in.
- pkt_valid  out  1  high for header and payload bytes, low for parity.
- tx_active  out  1  high from start acceptance until GAP ends.
- done  out  1  one-cycle pulse when the parity byte is consumed.
- start_err  out  1  one-cycle pulse when start is rejected.
- err_cnt  out  8  rising edges of err, saturating at 255.

Behaviour:
- Reset (async, any state): FSM to IDLE; buffer pointers, parity and err_cnt cleared.
  - data_out=0, pkt_valid=0, pld_ready=0, tx_active=0, done=0, start_err=0.
  - Buffer contents are don't-care.
- All outputs are registered.
- Consume rule: the byte on data_out is consumed at a rising edge where state is HEADER, PAYLOAD or PARITY and busy=0. While busy=1, data_out and pkt_valid hold unchanged.
- IDLE:
  - start with dest_addr!=3 and payload_len!=0: latch addr, len and inject_err; header = {payload_len, dest_addr}; parity = header; go to LOAD; tx_active=1.
  - Illegal start: start_err pulses the next cycle; stay in IDLE.
- LOAD:
  - pld_ready=1.
  - Each pld_valid&&pld_ready writes buf[wptr], wptr++, parity ^= pld_data.
  - After len bytes: pld_ready=0 and go to HEADER. The next cycle shows data_out=header, pkt_valid=1.
  - No timeout; LOAD waits indefinitely for bytes.
- HEADER: on consume, go to PAYLOAD and present buf[0] with pkt_valid=1.
- PAYLOAD:
  - On consume of byte i<len-1, present buf[i+1].
  - On consume of byte len-1, present parity (xor 0x01 if inject_err latched) with pkt_valid=0, and go to PARITY.
- PARITY: on consume, pulse done, data_out=0, go to GAP.
- GAP: hold for GAP_CYCLES cycles, then go to IDLE with tx_active=0. start is ignored (no start_err) outside IDLE.
- Sustained rate with busy=0 is one byte per cycle. The router sees len+2 bytes: header, len payload bytes, parity.
- err_cnt: increments on each 0->1 of err (a registered err_d is needed), in any state; holds at 255.
- Simultaneous err edge and reset: reset wins.
- The read pointer is 6-bit, so len=63 reads indices 0..62 with no wrap. The write pointer clears at each LOAD entry.

Decomposition:
- Shared package router_pkg: ADDR_INVALID=2'd3, header field widths (LEN_W=6, ADDR_W=2), and the FSM state enum {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP}, reusable by router monitors.
- Sub-module tx_payload_buf: 64x8 single-write/single-read register array with synchronous write and combinational read. Instantiated once.

Test Plan:
- start, addr=1, len=3; payload 0x11,0x22,0x33; busy=0 -> data_out 0x0D (pv=1), 0x11, 0x22, 0x33 (pv=1), 0x0D (pv=0) on consecutive cycles; done pulses once.
- Same packet with busy=1 for 3 cycles while 0x22 is presented -> 0x22 held 4 cycles, pkt_valid stays 1, no byte lost or duplicated.
- start with dest_addr=3 or payload_len=0 -> start_err pulse, pld_ready stays 0, tx_active stays 0.
- inject_err=1 on the first packet -> parity 0x0C sent. Router err pulse -> err_cnt=1. A second clean packet -> err_cnt unchanged.
- len=63 with payload bytes 0x00..0x3E -> 65 bytes sent; parity = 0xFE ^ XOR(0x00..0x3E).
- Assert reset while the 2nd payload byte is presented -> all outputs 0 immediately. A following legal start sends a complete, correct packet.
